// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Purpose:
//   Turns one ICache miss at a time into a 64-byte TileLink Get on the A
//   channel, then collects the two 256-bit AccessAckData beats returned on D
//   and presents them as a single 512-bit line on the ICache refill port.
//   The block sits directly upstream of the SRAM instruction responder: it
//   drives the responder's A channel and sinks its D channel (no d_ready, so
//   every D beat is consumed in the cycle it is presented).
//
//   FSM: IDLE -> REQ -> WAIT_D -> RESP_OUT -> IDLE
//
// Ports:
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   miss_valid/ready      miss request handshake; miss_ready = (state == IDLE)
//   miss_addr             miss byte address, any alignment
//   a_valid/a_ready       A-channel request handshake (a_valid registered)
//   a_bits_source         source ID of the outstanding request
//   a_bits_address        64B-aligned line address
//   d_valid               D beat present (always sunk)
//   d_bits_opcode         4'h1 = AccessAckData
//   d_bits_source         beat source ID
//   d_bits_data           beat payload
//   d_bits_corrupt        beat corrupt flag
//   refill_valid/ready    assembled-line handshake towards the ICache
//   refill_addr           line address of the refill
//   refill_data           {beat1, beat0}
//   refill_corrupt        OR of beat corrupt flags (also set on timeout)
//   refill_timeout        line closed by the WAIT_D watchdog
//
// Configuration:
//   REFILL_TIMEOUT_EN     when defined, a watchdog closes WAIT_D after
//                         TIMEOUT_CYC cycles without the second beat. When
//                         undefined, WAIT_D waits indefinitely and
//                         refill_timeout is tied low.
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int ADDR_W      = 48,
    parameter int BEAT_W      = 256,
    parameter int SRC_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_W-1:0]     miss_addr,

    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [SRC_W-1:0]      a_bits_source,
    output logic [ADDR_W-1:0]     a_bits_address,

    input  logic                  d_valid,
    input  logic [3:0]            d_bits_opcode,
    input  logic [SRC_W-1:0]      d_bits_source,
    input  logic [BEAT_W-1:0]     d_bits_data,
    input  logic                  d_bits_corrupt,

    output logic                  refill_valid,
    input  logic                  refill_ready,
    output logic [ADDR_W-1:0]     refill_addr,
    output logic [2*BEAT_W-1:0]   refill_data,
    output logic                  refill_corrupt,
    output logic                  refill_timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_D   = 2'd2,
        RESP_OUT = 2'd3
    } state_t;

    localparam logic [3:0]       OPC_ACCESS_ACK_DATA = 4'h1;
    localparam logic [SRC_W-1:0] SRC_ONE             = {{(SRC_W-1){1'b0}}, 1'b1};

    state_t                 state_r;
    logic                   a_valid_r;
    logic [SRC_W-1:0]       src_id_r;
    logic [ADDR_W-1:0]      addr_r;
    logic [2*BEAT_W-1:0]    data_r;
    logic                   beat_cnt_r;
    logic                   refill_valid_r;
    logic                   corrupt_r;

    logic                   beat_ok_s;
    logic                   last_beat_s;

`ifdef REFILL_TIMEOUT_EN
    // Counter wide enough to hold TIMEOUT_CYC-1.
    localparam int            TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

    logic [TO_W-1:0]        to_cnt_r;
    logic                   timeout_r;
`else
    // Watchdog depth is meaningless without the watchdog; keep it referenced.
    logic [31:0]            unused_timeout_cfg_s;
    assign unused_timeout_cfg_s = 32'(TIMEOUT_CYC);
`endif

    // The low six address bits are dropped by line alignment.
    logic                   unused_addr_low_s;
    assign unused_addr_low_s = ^miss_addr[5:0];

    // A beat only counts when it belongs to the current request and carries
    // data; anything else on D (stale sources, non-data opcodes, beats that
    // arrive outside WAIT_D) is sunk and forgotten.
    assign beat_ok_s   = d_valid
                      && (d_bits_opcode == OPC_ACCESS_ACK_DATA)
                      && (d_bits_source == src_id_r)
                      && (state_r == WAIT_D);
    assign last_beat_s = beat_ok_s && beat_cnt_r;

    // Refill FSM with all of its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            a_valid_r      <= 1'b0;
            src_id_r       <= {SRC_W{1'b0}};
            addr_r         <= {ADDR_W{1'b0}};
            data_r         <= {(2*BEAT_W){1'b0}};
            beat_cnt_r     <= 1'b0;
            refill_valid_r <= 1'b0;
            corrupt_r      <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
            to_cnt_r       <= {TO_W{1'b0}};
            timeout_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_valid) begin
                        // Per-line status and data start clean so a timed-out
                        // line reports zeros for the beat that never came.
                        addr_r     <= {miss_addr[ADDR_W-1:6], 6'b00_0000};
                        data_r     <= {(2*BEAT_W){1'b0}};
                        beat_cnt_r <= 1'b0;
                        corrupt_r  <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
                        timeout_r  <= 1'b0;
`endif
                        a_valid_r  <= 1'b1;
                        state_r    <= REQ;
                    end else begin
                        state_r    <= IDLE;
                    end
                end

                REQ: begin
                    // Address and source are held in registers, so they stay
                    // stable for as long as the responder stalls.
                    if (a_ready) begin
                        a_valid_r <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
                        to_cnt_r  <= {TO_W{1'b0}};
`endif
                        state_r   <= WAIT_D;
                    end else begin
                        a_valid_r <= 1'b1;
                        state_r   <= REQ;
                    end
                end

                WAIT_D: begin
                    if (last_beat_s) begin
                        data_r[2*BEAT_W-1:BEAT_W] <= d_bits_data;
                        corrupt_r      <= corrupt_r | d_bits_corrupt;
                        beat_cnt_r     <= 1'b0;
                        refill_valid_r <= 1'b1;
                        state_r        <= RESP_OUT;
                    end else begin
                        if (beat_ok_s) begin
                            data_r[BEAT_W-1:0] <= d_bits_data;
                            corrupt_r  <= corrupt_r | d_bits_corrupt;
                            beat_cnt_r <= 1'b1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r;
                        end
`ifdef REFILL_TIMEOUT_EN
                        // Last allowed WAIT_D cycle without the second beat:
                        // close the line as corrupt so the ICache never
                        // caches it.
                        if (to_cnt_r == TO_LAST) begin
                            timeout_r      <= 1'b1;
                            corrupt_r      <= 1'b1;
                            refill_valid_r <= 1'b1;
                            state_r        <= RESP_OUT;
                        end else begin
                            to_cnt_r       <= to_cnt_r + TO_ONE;
                            state_r        <= WAIT_D;
                        end
`else
                        state_r <= WAIT_D;
`endif
                    end
                end

                RESP_OUT: begin
                    if (refill_ready) begin
                        // Bumping the source makes any late beat of this
                        // request mismatch and get dropped.
                        refill_valid_r <= 1'b0;
                        src_id_r       <= src_id_r + SRC_ONE;
                        beat_cnt_r     <= 1'b0;
                        state_r        <= IDLE;
                    end else begin
                        refill_valid_r <= 1'b1;
                        state_r        <= RESP_OUT;
                    end
                end

                default: begin
                    a_valid_r      <= 1'b0;
                    refill_valid_r <= 1'b0;
                    beat_cnt_r     <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

    assign miss_ready     = (state_r == IDLE);
    assign a_valid        = a_valid_r;
    assign a_bits_source  = src_id_r;
    assign a_bits_address = addr_r;

    assign refill_valid   = refill_valid_r;
    assign refill_addr    = addr_r;
    assign refill_data    = data_r;
    assign refill_corrupt = corrupt_r;
`ifdef REFILL_TIMEOUT_EN
    assign refill_timeout = timeout_r;
`else
    assign refill_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Directed self-checking bench for icache_refill_ctrl. Inputs are driven and
// outputs sampled 1 ns after each rising edge. Each scenario task carries its
// own hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    localparam int ADDR_W = 48;
    localparam int BEAT_W = 256;
    localparam int SRC_W  = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 miss_valid;
    logic                 miss_ready;
    logic [ADDR_W-1:0]    miss_addr;
    logic                 a_valid;
    logic                 a_ready;
    logic [SRC_W-1:0]     a_bits_source;
    logic [ADDR_W-1:0]    a_bits_address;
    logic                 d_valid;
    logic [3:0]           d_bits_opcode;
    logic [SRC_W-1:0]     d_bits_source;
    logic [BEAT_W-1:0]    d_bits_data;
    logic                 d_bits_corrupt;
    logic                 refill_valid;
    logic                 refill_ready;
    logic [ADDR_W-1:0]    refill_addr;
    logic [2*BEAT_W-1:0]  refill_data;
    logic                 refill_corrupt;
    logic                 refill_timeout;

    int                   n_cmp;
    int                   n_err;
    logic [SRC_W-1:0]     exp_src;

    icache_refill_ctrl #(
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .SRC_W(SRC_W), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
        .d_valid(d_valid), .d_bits_opcode(d_bits_opcode),
        .d_bits_source(d_bits_source), .d_bits_data(d_bits_data),
        .d_bits_corrupt(d_bits_corrupt),
        .refill_valid(refill_valid), .refill_ready(refill_ready),
        .refill_addr(refill_addr), .refill_data(refill_data),
        .refill_corrupt(refill_corrupt), .refill_timeout(refill_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute bound on the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss_valid     = 1'b0;
        miss_addr      = 48'h0;
        a_ready        = 1'b0;
        d_valid        = 1'b0;
        d_bits_opcode  = 4'h0;
        d_bits_source  = 4'h0;
        d_bits_data    = 256'h0;
        d_bits_corrupt = 1'b0;
        refill_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_src = 4'h0;
    endtask

    // Present one miss while in IDLE; returns in the first REQ cycle.
    task automatic send_miss(input logic [ADDR_W-1:0] addr);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
    endtask

    // Accept the A request; returns in the first WAIT_D cycle.
    task automatic accept_a();
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
    endtask

    // One D beat for a single cycle.
    task automatic send_beat(input logic [3:0] op, input logic [SRC_W-1:0] src,
                             input logic [BEAT_W-1:0] data, input logic cor);
        d_valid        = 1'b1;
        d_bits_opcode  = op;
        d_bits_source  = src;
        d_bits_data    = data;
        d_bits_corrupt = cor;
        tick();
        d_valid        = 1'b0;
        d_bits_corrupt = 1'b0;
    endtask

    task automatic take_refill();
        refill_ready = 1'b1;
        tick();
        refill_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL reset_miss_ready got %0h exp 1", miss_ready); end
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got %0h exp 0", a_valid); end
        n_cmp++; if (refill_valid !== 1'b0) begin n_err++; $display("FAIL reset_refill_valid got %0h exp 0", refill_valid); end
        n_cmp++; if ({refill_corrupt, refill_timeout} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %0h exp 0", {refill_corrupt, refill_timeout}); end
        n_cmp++; if (a_bits_source !== 4'h0) begin n_err++; $display("FAIL reset_source got %0h exp 0", a_bits_source); end
        n_cmp++; if (refill_data !== 512'h0) begin n_err++; $display("FAIL reset_data got %0h exp 0", refill_data); end
        rst_n = 1'b1;
        exp_src = 4'h0;
        tick();
    endtask

    task automatic test_basic();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        d0 = {8{32'hAAAA_AAAA}};
        d1 = {8{32'hBBBB_BBBB}};
        miss_valid = 1'b1;
        miss_addr  = 48'h0000_8000_1234;
        a_ready    = 1'b1;
        n_cmp++; if (miss_ready !== 1'b1) begin n_err++; $display("FAIL basic_miss_ready got %0h exp 1", miss_ready); end
        tick();                                   // cycle 0: miss handshake
        miss_valid = 1'b0;
        n_cmp++; if (a_valid !== 1'b1) begin n_err++; $display("FAIL basic_a_valid got %0h exp 1", a_valid); end
        n_cmp++; if (a_bits_address !== 48'h0000_8000_1200) begin n_err++; $display("FAIL basic_a_addr got %0h exp 800001200", a_bits_address); end
        n_cmp++; if (a_bits_source !== 4'h0) begin n_err++; $display("FAIL basic_a_src got %0h exp 0", a_bits_source); end
        n_cmp++; if (miss_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy got %0h exp 0", miss_ready); end
        tick();                                   // cycle 1: A handshake
        a_ready = 1'b0;
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL basic_a_drop got %0h exp 0", a_valid); end
        send_beat(4'h1, 4'h0, d0, 1'b0);          // cycle 2
        n_cmp++; if (refill_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %0h exp 0", refill_valid); end
        send_beat(4'h1, 4'h0, d1, 1'b0);          // cycle 3
        // cycle 4
        n_cmp++; if (refill_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency got %0h exp 1", refill_valid); end
        n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL basic_data got %0h exp %0h", refill_data, {d1, d0}); end
        n_cmp++; if (refill_addr !== 48'h0000_8000_1200) begin n_err++; $display("FAIL basic_refill_addr got %0h exp 800001200", refill_addr); end
        n_cmp++; if ({refill_corrupt, refill_timeout} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %0h exp 0", {refill_corrupt, refill_timeout}); end
        take_refill();
        n_cmp++; if ({refill_valid, miss_ready} !== 2'b01) begin n_err++; $display("FAIL basic_done got %0h exp 1", {refill_valid, miss_ready}); end
        exp_src = 4'h1;
    endtask

    task automatic test_a_backpressure();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        d0 = {8{32'h1111_1111}};
        d1 = {8{32'h2222_2222}};
        send_miss(48'h1234_5678_9ABC);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({a_valid, miss_ready} !== 2'b10) begin n_err++; $display("FAIL abp_hold[%0d] got %0h exp 2", i, {a_valid, miss_ready}); end
            n_cmp++; if (a_bits_address !== 48'h1234_5678_9A80) begin n_err++; $display("FAIL abp_addr[%0d] got %0h exp 123456789a80", i, a_bits_address); end
            n_cmp++; if (a_bits_source !== exp_src) begin n_err++; $display("FAIL abp_src[%0d] got %0h exp %0h", i, a_bits_source, exp_src); end
            tick();
        end
        accept_a();
        n_cmp++; if (a_valid !== 1'b0) begin n_err++; $display("FAIL abp_a_drop got %0h exp 0", a_valid); end
        send_beat(4'h1, exp_src, d0, 1'b0);
        send_beat(4'h1, exp_src, d1, 1'b0);
        n_cmp++; if (refill_valid !== 1'b1) begin n_err++; $display("FAIL abp_valid got %0h exp 1", refill_valid); end
        n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL abp_data got %0h exp %0h", refill_data, {d1, d0}); end
        take_refill();
        exp_src = exp_src + 4'h1;
    endtask

    task automatic test_refill_backpressure();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        d0 = {8{32'h0123_4567}};
        d1 = {8{32'h89AB_CDEF}};
        a_ready = 1'b1;
        send_miss(48'h0000_0000_0FC0);
        tick();
        a_ready = 1'b0;
        send_beat(4'h1, exp_src, d0, 1'b0);
        send_beat(4'h1, exp_src, d1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (refill_valid !== 1'b1) begin n_err++; $display("FAIL rbp_valid[%0d] got %0h exp 1", i, refill_valid); end
            n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL rbp_data[%0d] got %0h exp %0h", i, refill_data, {d1, d0}); end
            n_cmp++; if ({refill_addr, refill_corrupt} !== {48'h0000_0000_0FC0, 1'b0}) begin n_err++; $display("FAIL rbp_addr[%0d] got %0h exp fc0", i, refill_addr); end
            send_beat(4'h1, exp_src, {8{32'hDEAD_0000 + i}}, 1'b1);
        end
        n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL rbp_data_end got %0h exp %0h", refill_data, {d1, d0}); end
        n_cmp++; if (refill_corrupt !== 1'b0) begin n_err++; $display("FAIL rbp_corrupt got %0h exp 0", refill_corrupt); end
        take_refill();
        n_cmp++; if ({refill_valid, miss_ready} !== 2'b01) begin n_err++; $display("FAIL rbp_done got %0h exp 1", {refill_valid, miss_ready}); end
        exp_src = exp_src + 4'h1;
    endtask

    task automatic test_bad_beats();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        d0 = {8{32'h5555_0000}};
        d1 = {8{32'h6666_FFFF}};
        a_ready = 1'b1;
        send_miss(48'h0000_0000_2040);
        tick();
        a_ready = 1'b0;
        send_beat(4'h1, exp_src + 4'h1, {8{32'hBAD0_0001}}, 1'b0);
        send_beat(4'h0, exp_src, {8{32'hBAD0_0002}}, 1'b0);
        n_cmp++; if (refill_valid !== 1'b0) begin n_err++; $display("FAIL bad_no_close got %0h exp 0", refill_valid); end
        send_beat(4'h1, exp_src, d0, 1'b0);
        n_cmp++; if (refill_valid !== 1'b0) begin n_err++; $display("FAIL bad_one_beat got %0h exp 0", refill_valid); end
        send_beat(4'h1, exp_src, d1, 1'b1);
        n_cmp++; if (refill_valid !== 1'b1) begin n_err++; $display("FAIL bad_valid got %0h exp 1", refill_valid); end
        n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL bad_data got %0h exp %0h", refill_data, {d1, d0}); end
        n_cmp++; if (refill_corrupt !== 1'b1) begin n_err++; $display("FAIL bad_corrupt got %0h exp 1", refill_corrupt); end
        take_refill();
        exp_src = exp_src + 4'h1;
    endtask

    task automatic test_back_to_back();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        logic [3:0]        want;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            want = 4'(i % 16);
            d0 = {8{32'(i) * 32'h0101_0101}};
            d1 = ~d0;
            a_ready = 1'b1;
            send_miss(48'(i) << 6);
            n_cmp++; if (a_bits_source !== want) begin n_err++; $display("FAIL b2b_src[%0d] got %0h exp %0h", i, a_bits_source, want); end
            tick();
            a_ready = 1'b0;
            send_beat(4'h1, want, d0, 1'b0);
            send_beat(4'h1, want, d1, 1'b0);
            n_cmp++; if (refill_data !== {d1, d0}) begin n_err++; $display("FAIL b2b_data[%0d] got %0h exp %0h", i, refill_data, {d1, d0}); end
            take_refill();
        end
        exp_src = 4'h1;
    endtask

    task automatic test_timeout();
        a_ready = 1'b1;
        send_miss(48'h0000_0000_1000);
        tick();
        a_ready = 1'b0;
`ifdef REFILL_TIMEOUT_EN
        repeat (63) tick();
        n_cmp++; if (refill_valid !== 1'b0) begin n_err++; $display("FAIL to_early got %0h exp 0", refill_valid); end
        tick();
        n_cmp++; if ({refill_valid, refill_timeout, refill_corrupt} !== 3'b111) begin n_err++; $display("FAIL to_flags got %0h exp 7", {refill_valid, refill_timeout, refill_corrupt}); end
        n_cmp++; if (refill_data !== 512'h0) begin n_err++; $display("FAIL to_data got %0h exp 0", refill_data); end
        n_cmp++; if (refill_addr !== 48'h0000_0000_1000) begin n_err++; $display("FAIL to_addr got %0h exp 1000", refill_addr); end
        take_refill();
        send_beat(4'h1, exp_src, {8{32'h7777_7777}}, 1'b0);
        n_cmp++; if ({refill_valid, miss_ready} !== 2'b01) begin n_err++; $display("FAIL to_late_beat got %0h exp 1", {refill_valid, miss_ready}); end
        exp_src = exp_src + 4'h1;
`else
        repeat (100) tick();
        n_cmp++; if ({refill_valid, miss_ready, refill_timeout} !== 3'b000) begin n_err++; $display("FAIL to_wait got %0h exp 0", {refill_valid, miss_ready, refill_timeout}); end
        apply_reset();
`endif
    endtask

    task automatic test_reset_mid();
        logic [BEAT_W-1:0] d0;
        logic [BEAT_W-1:0] d1;
        d0 = {8{32'hC0C0_C0C0}};
        d1 = {8{32'hD1D1_D1D1}};
        // Make sure the source is non-zero before the reset.
        a_ready = 1'b1;
        send_miss(48'h0000_0000_3000);
        tick();
        a_ready = 1'b0;
        send_beat(4'h1, exp_src, d0, 1'b0);
        send_beat(4'h1, exp_src, d1, 1'b0);
        take_refill();
        exp_src = exp_src + 4'h1;
        // Interrupted refill: beat0 accepted, then reset.
        a_ready = 1'b1;
        send_miss(48'h0000_0000_4000);
        tick();
        a_ready = 1'b0;
        send_beat(4'h1, exp_src, d0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_valid, refill_valid, miss_ready} !== 3'b001) begin n_err++; $display("FAIL rstm_ctrl got %0h exp 1", {a_valid, refill_valid, miss_ready}); end
        n_cmp++; if ({refill_corrupt, refill_timeout, a_bits_source} !== 6'h00) begin n_err++; $display("FAIL rstm_src got %0h exp 0", {refill_corrupt, refill_timeout, a_bits_source}); end
        n_cmp++; if ({refill_addr, refill_data} !== 560'h0) begin n_err++; $display("FAIL rstm_regs got %0h exp 0", {refill_addr, refill_data}); end
        tick();
        rst_n = 1'b1;
        send_beat(4'h1, exp_src, d1, 1'b0);
        n_cmp++; if ({refill_valid, miss_ready} !== 2'b01) begin n_err++; $display("FAIL rstm_stale got %0h exp 1", {refill_valid, miss_ready}); end
        a_ready = 1'b1;
        send_miss(48'h0000_0000_5010);
        n_cmp++; if (a_bits_source !== 4'h0) begin n_err++; $display("FAIL rstm_new_src got %0h exp 0", a_bits_source); end
        tick();
        a_ready = 1'b0;
        send_beat(4'h1, 4'h0, d1, 1'b0);
        send_beat(4'h1, 4'h0, d0, 1'b0);
        n_cmp++; if (refill_data !== {d0, d1}) begin n_err++; $display("FAIL rstm_data got %0h exp %0h", refill_data, {d0, d1}); end
        n_cmp++; if ({refill_addr, refill_corrupt} !== {48'h0000_0000_5000, 1'b0}) begin n_err++; $display("FAIL rstm_addr got %0h exp 5000", refill_addr); end
        take_refill();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_src = 4'h0;
        test_reset();
        test_basic();
        test_a_backpressure();
        test_refill_backpressure();
        test_bad_beats();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
